// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the byte-serial RAM controller: reset/stall levels,
// memory access size encodings and controller state encodings.
package ram_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic STOP       = 1'b1;

    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    typedef enum logic [1:0] {
        RAMC_IDLE  = 2'b00,
        RAMC_READ  = 2'b01,
        RAMC_WRITE = 2'b10
    } ramc_state_t;

    // Byte count of a MEM access; the reserved encoding 11 behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_SZ_B: size_bytes = 3'd1;
            MEM_SZ_H: size_bytes = 3'd2;
            MEM_SZ_W: size_bytes = 3'd4;
            default:  size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_ctrl.sv
// Byte-serial controller between the pipeline (IF fetches, MEM loads/stores)
// and a single-port 8-bit RAM with one cycle of read latency.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic                  stall_req,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_dout,
    output logic                  ram_wr,
    input  logic [7:0]            ram_din
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    ramc_state_t state, state_nx;
    logic [2:0]  beat;
    logic [2:0]  nbytes;
    logic        is_if;
    logic [31:0] asm_data;
    logic [31:0] wbuf;
    logic [1:0]  cap_idx;
    logic        any_done;
    logic        accept_mem, accept_if;
    logic        read_end, write_end, flush_abort;

    assign any_done = if_done | mem_done;
    // In read beat b the byte requested in beat b-1 is on ram_din.
    assign cap_idx  = beat[1:0] - 2'd1;

    // Depends only on requests and registered done flags, never on the stall vector.
    assign stall_req = ((mem_req & ~mem_done) | (if_req & ~if_done & ~if_flush)) ? STOP : ~STOP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) state <= RAMC_IDLE;
        else                   state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        accept_mem  = 1'b0;
        accept_if   = 1'b0;
        read_end    = 1'b0;
        write_end   = 1'b0;
        flush_abort = 1'b0;
        case (state)
            RAMC_IDLE: begin
                // The done cycle never re-accepts: the requester drops req on seeing done.
                if (!any_done) begin
                    if (mem_req) begin
                        accept_mem = 1'b1;
                        state_nx   = mem_we ? RAMC_WRITE : RAMC_READ;
                    end else if (if_req && !if_flush) begin
                        accept_if = 1'b1;
                        state_nx  = RAMC_READ;
                    end
                end
            end
            RAMC_READ: begin
                if (is_if && if_flush) begin
                    flush_abort = 1'b1;
                    state_nx    = RAMC_IDLE;
                end else if (beat == nbytes) begin
                    read_end = 1'b1;
                    state_nx = RAMC_IDLE;
                end
            end
            RAMC_WRITE: begin
                if (beat == nbytes - 3'd1) begin
                    write_end = 1'b1;
                    state_nx  = RAMC_IDLE;
                end
            end
            default: state_nx = RAMC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_inst   <= '0;
            mem_rdata <= '0;
            ram_a     <= '0;
            ram_dout  <= '0;
            ram_wr    <= 1'b0;
            beat      <= '0;
            nbytes    <= '0;
            is_if     <= 1'b0;
            asm_data  <= '0;
            wbuf      <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                RAMC_IDLE: begin
                    if (accept_mem) begin
                        ram_a    <= mem_addr;
                        nbytes   <= size_bytes(mem_size);
                        is_if    <= 1'b0;
                        beat     <= '0;
                        asm_data <= '0;
                        ram_wr   <= mem_we;
                        ram_dout <= mem_wdata[7:0];
                        wbuf     <= {8'h00, mem_wdata[31:8]};
                    end else if (accept_if) begin
                        ram_a    <= if_addr;
                        nbytes   <= 3'd4;
                        is_if    <= 1'b1;
                        beat     <= '0;
                        asm_data <= '0;
                    end
                end
                RAMC_READ: begin
                    if (!flush_abort) begin
                        beat <= beat + 3'd1;
                        if (beat != 3'd0)
                            asm_data[{cap_idx, 3'b000} +: 8] <= ram_din;
                        if (beat < nbytes - 3'd1)
                            ram_a <= ram_a + ADDR_ONE;
                        // Last byte merges straight into the registered output.
                        if (read_end) begin
                            if (is_if) begin
                                if_inst <= asm_data | ({24'h0, ram_din} << {cap_idx, 3'b000});
                                if_done <= 1'b1;
                            end else begin
                                mem_rdata <= asm_data | ({24'h0, ram_din} << {cap_idx, 3'b000});
                                mem_done  <= 1'b1;
                            end
                        end
                    end
                end
                RAMC_WRITE: begin
                    if (write_end) begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                    end else begin
                        beat     <= beat + 3'd1;
                        ram_a    <= ram_a + ADDR_ONE;
                        ram_dout <= wbuf[7:0];
                        wbuf     <= wbuf >> 8;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: fetch, store, priority, unaligned load,
// flush abort and reset mid-write, against a small read-only RAM model.
module tb_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        stall_req;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    int tests = 0;
    int fails = 0;

    ram_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .stall_req(stall_req),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100:  rom = 8'h13;
            32'h101:  rom = 8'h05;
            32'h102:  rom = 8'h00;
            32'h103:  rom = 8'h00;
            32'h200:  rom = 8'h93;
            32'h201:  rom = 8'h00;
            32'h202:  rom = 8'h10;
            32'h203:  rom = 8'h00;
            32'h2003: rom = 8'h80;
            32'h3001: rom = 8'h34;
            32'h3002: rom = 8'h12;
            default:  rom = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) ram_din <= rom(ram_a);

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] wd;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = '0; mem_wdata = '0;

        next();
        chk("rst_if_done", {31'b0, if_done}, 32'd0);
        chk("rst_mem_done", {31'b0, mem_done}, 32'd0);
        chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", {24'b0, ram_dout}, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_stall", {31'b0, stall_req}, 32'd0);
        rst = 1'b0;
        next();

        // IF fetch at 0x100
        if_req = 1'b1; if_addr = 32'h100; #1;
        chk("if_stall_A", {31'b0, stall_req}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            next();
            chk("if_ram_a", ram_a, 32'h100 + k);
            chk("if_ram_wr", {31'b0, ram_wr}, 32'd0);
            chk("if_stall", {31'b0, stall_req}, 32'd1);
        end
        next();
        chk("if_done_A5", {31'b0, if_done}, 32'd0);
        chk("if_stall_A5", {31'b0, stall_req}, 32'd1);
        next();
        chk("if_done_A6", {31'b0, if_done}, 32'd1);
        chk("if_inst_A6", if_inst, 32'h0000_0513);
        chk("if_stall_A6", {31'b0, stall_req}, 32'd0);
        if_req = 1'b0;
        next();
        chk("if_done_A7", {31'b0, if_done}, 32'd0);

        // MEM store word 0xDEADBEEF at 0x1000
        wd = 32'hDEAD_BEEF;
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h1000; mem_wdata = wd;
        for (int k = 0; k < 4; k++) begin
            next();
            chk("st_ram_wr", {31'b0, ram_wr}, 32'd1);
            chk("st_ram_a", ram_a, 32'h1000 + k);
            chk("st_ram_dout", {24'b0, ram_dout}, {24'b0, wd[8*k +: 8]});
        end
        next();
        chk("st_done_A5", {31'b0, mem_done}, 32'd1);
        chk("st_wr_A5", {31'b0, ram_wr}, 32'd0);
        chk("st_stall_A5", {31'b0, stall_req}, 32'd0);
        mem_req = 1'b0; mem_we = 1'b0;
        next();

        // MEM load byte and IF fetch requested together
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h2003;
        if_req = 1'b1; if_addr = 32'h100;
        next();
        chk("pri_ram_a_A1", ram_a, 32'h2003);
        next();
        next();
        chk("pri_mem_done_A3", {31'b0, mem_done}, 32'd1);
        chk("pri_rdata_A3", mem_rdata, 32'h0000_0080);
        chk("pri_if_done_A3", {31'b0, if_done}, 32'd0);
        chk("pri_stall_A3", {31'b0, stall_req}, 32'd1);
        mem_req = 1'b0;
        next();
        chk("pri_mem_done_A4", {31'b0, mem_done}, 32'd0);
        next();
        chk("pri_if_ram_a_A5", ram_a, 32'h100);
        for (int k = 0; k < 4; k++) next();
        chk("pri_if_done_A9", {31'b0, if_done}, 32'd0);
        next();
        chk("pri_if_done_A10", {31'b0, if_done}, 32'd1);
        chk("pri_if_inst_A10", if_inst, 32'h0000_0513);
        if_req = 1'b0;
        next();

        // Unaligned half load at 0x3001; req held through the done cycle
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b01; mem_addr = 32'h3001;
        next();
        chk("half_ram_a_A1", ram_a, 32'h3001);
        next();
        chk("half_ram_a_A2", ram_a, 32'h3002);
        next();
        chk("half_done_A3", {31'b0, mem_done}, 32'd0);
        next();
        chk("half_done_A4", {31'b0, mem_done}, 32'd1);
        chk("half_rdata_A4", mem_rdata, 32'h0000_1234);
        next();
        chk("half_no_reaccept", ram_a, 32'h3002);
        chk("half_done_A5", {31'b0, mem_done}, 32'd0);
        mem_req = 1'b0;
        next();

        // Size 11 behaves as a word
        mem_req = 1'b1; mem_size = 2'b11; mem_addr = 32'h100;
        for (int k = 0; k < 6; k++) next();
        chk("sz11_done", {31'b0, mem_done}, 32'd1);
        chk("sz11_rdata", mem_rdata, 32'h0000_0513);
        mem_req = 1'b0;
        next();

        // Flush during a fetch, then a new fetch at 0x200
        if_req = 1'b1; if_addr = 32'h100;
        next();
        next();
        if_flush = 1'b1; #1;
        chk("fl_stall_A2", {31'b0, stall_req}, 32'd0);
        next();
        if_flush = 1'b0; if_addr = 32'h200;
        chk("fl_no_done_A3", {31'b0, if_done}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            next();
            chk("fl_no_done", {31'b0, if_done}, 32'd0);
            if (k == 0) chk("fl_new_ram_a", ram_a, 32'h200);
        end
        next();
        chk("fl_done_A9", {31'b0, if_done}, 32'd1);
        chk("fl_inst_A9", if_inst, 32'h0010_0093);
        if_req = 1'b0;
        next();

        // Reset in the middle of a store, then replay
        wd = 32'hCAFE_F00D;
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h1100; mem_wdata = wd;
        next();
        chk("rw_wr_A1", {31'b0, ram_wr}, 32'd1);
        next();
        rst = 1'b1; mem_req = 1'b0; #1;
        chk("rw_wr_async", {31'b0, ram_wr}, 32'd0);
        chk("rw_ram_a", ram_a, 32'd0);
        chk("rw_ram_dout", {24'b0, ram_dout}, 32'd0);
        chk("rw_mem_done", {31'b0, mem_done}, 32'd0);
        chk("rw_if_inst", if_inst, 32'd0);
        chk("rw_mem_rdata", mem_rdata, 32'd0);
        chk("rw_stall", {31'b0, stall_req}, 32'd0);
        next();
        chk("rw_mem_done_2", {31'b0, mem_done}, 32'd0);
        rst = 1'b0; mem_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next();
            chk("rp_ram_wr", {31'b0, ram_wr}, 32'd1);
            chk("rp_ram_a", ram_a, 32'h1100 + k);
            chk("rp_ram_dout", {24'b0, ram_dout}, {24'b0, wd[8*k +: 8]});
        end
        next();
        chk("rp_done", {31'b0, mem_done}, 32'd1);
        chk("rp_wr_off", {31'b0, ram_wr}, 32'd0);
        mem_req = 1'b0;
        next();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
